uart_count_reporter: RTL and testbench
======================================

Name: uart_count_reporter

Overview:
Parametrised multi-channel event counter with periodic UART telemetry. Counts rising edges on NUM_CH asynchronous event inputs (switches, sensor strobes), snapshots all counters atomically on a timer or on request, and streams the snapshot as one framed 8N1 packet on a single tx line. Sits at FPGA top level between board inputs and the host UART.

Parameters:
NUM_CH, 4, number of event channels (1..16)
CNT_WIDTH, 16, counter width in bits (1..32); CNT_BYTES = ceil(CNT_WIDTH/8)
CLKS_PER_BIT, 104, clk cycles per UART bit (>=2)
REPORT_PERIOD, 1000000, clk cycles between automatic reports (>=2)
CLEAR_ON_SNAP, 0, 1 = live counters cleared when snapshotted

Ports:
clk  input  1  system clock
rst  input  1  asynchronous active-high reset
ev_in  input  NUM_CH  raw event inputs, asynchronous to clk
report_req  input  1  single-cycle manual report request
tx  output  1  UART serial out, idle high
busy  output  1  high while a frame is being sent
frame_done  output  1  one-cycle pulse after last stop bit of a frame

Behaviour:
- Reset: tx=1, busy=0, frame_done=0, live counters, snapshots, period timer, pending flag, synchronisers all 0. Reset mid-frame aborts immediately; tx returns to 1 asynchronously.
- Input path: each ev_in bit through 2-FF synchroniser, then rising-edge detect; counter increments one cycle after detected edge. Latency pin-to-count: 3 clk. Counter wraps modulo 2^CNT_WIDTH (all-ones + 1 -> 0).
- Trigger: period timer counts 0..REPORT_PERIOD-1, free-running, terminal count sets pending. report_req high also sets pending. Pending while busy is held (not queued twice); multiple triggers during one frame yield exactly one following frame.
- FSM states: IDLE, SNAP, SYNC, CH_ID, DATA, CSUM.
  IDLE: pending -> SNAP.
  SNAP (1 cycle): copy all live counters to snapshot regs, clear pending, busy=1 from this cycle. Edge counted in SNAP cycle goes to live counter only (snapshot holds pre-increment value). CLEAR_ON_SNAP=1: live counter -> 0, or 1 if edge same cycle.
  SYNC: send 0xA5.
  CH_ID: send channel index (0..NUM_CH-1).
  DATA: send CNT_BYTES bytes of snapshot, MSB first, zero-padded above CNT_WIDTH; after last byte, next channel CH_ID, else CSUM.
  CSUM: send XOR of all bytes after sync. Then frame_done pulse, busy=0, IDLE.
- Frame length: 2 + NUM_CH*(1+CNT_BYTES) bytes.
- Byte serialisation: 8N1, LSB first, each bit exactly CLKS_PER_BIT cycles. Start bit begins cycle after byte handed to serialiser; consecutive bytes back-to-back (no idle gap between stop and next start).
- frame_done asserts in the cycle after the last stop bit completes; busy deasserts same cycle. Pending set during frame -> SNAP next cycle after IDLE entry.

Optional Feature:
COUNT_REPORT_ASCII_EN: defined -> frame is printable ASCII: for each channel, hex digit of channel index, ':', 2*CNT_BYTES uppercase hex digits MSB first, ' '; frame ends with "\r\n"; no sync/checksum bytes. Undefined -> binary frame above. Snapshot, trigger, and timing rules unchanged.

Decomposition:
- Package uart_count_pkg: FSM state enum, SYNC_BYTE=0xA5, CNT_BYTES function, ASCII constants (':', ' ', CR, LF).
- Sub-module uart_tx_byte: 8-bit valid/ready serialiser parametrised by CLKS_PER_BIT; ready high only in idle or in the final cycle of stop bit to allow back-to-back bytes.

Test Plan:
- Reset: rst=1 for 5 cycles mid-frame -> tx=1, busy=0 immediately; after release no frame until trigger.
- Binary frame: NUM_CH=2, CNT_WIDTH=16, CLKS_PER_BIT=4; 3 edges ch0, 5 edges ch1, report_req -> bytes A5 00 00 03 01 00 05 07, each bit 4 clk, frame_done once.
- Wrap: CNT_WIDTH=8, 257 edges on ch0 -> snapshot reports 0x01.
- Trigger collision: REPORT_PERIOD=50, report_req pulses twice during a frame -> exactly one additional frame after frame_done.
- Snap edge race: CLEAR_ON_SNAP=1, edge landing in SNAP cycle -> current frame excludes it, next frame reports count 1.
- ASCII (COUNT_REPORT_ASCII_EN, NUM_CH=1, CNT_WIDTH=8, count 0x2A) -> "0:2A \r\n".

Source files
------------

// File: rtl/uart_count_pkg.sv
// Shared FSM state type, frame constants and helpers for uart_count_reporter.
package uart_count_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SNAP,
    ST_SYNC,
    ST_CH_ID,
    ST_DATA,
    ST_CSUM
  } state_t;

  localparam logic [7:0] SYNC_BYTE   = 8'hA5;
  localparam logic [7:0] ASCII_COLON = 8'h3A;
  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_LF    = 8'h0A;

  function automatic int cnt_bytes(input int width);
    return (width + 7) / 8;
  endfunction

  // Uppercase hex digit for a nibble.
  function automatic logic [7:0] hex_char(input logic [3:0] nib);
    return (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte serialiser with valid/ready handshake; ready also rises in the last
// stop-bit cycle so consecutive bytes go out with no idle gap.
module uart_tx_byte #(
  parameter int CLKS_PER_BIT = 104
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       tx
);
  localparam int CW = $clog2(CLKS_PER_BIT);

  logic          active_q, active_d;
  logic [7:0]    shift_q, shift_d;
  logic [3:0]    bit_q, bit_d;
  logic [CW-1:0] clk_cnt_q, clk_cnt_d;
  logic          tx_q, tx_d;
  logic          bit_end;

  assign bit_end  = (clk_cnt_q == CW'(CLKS_PER_BIT - 1));
  assign tx_ready = !active_q || (bit_q == 4'd9 && bit_end);
  assign tx       = tx_q;

  // bit_q: 0 = start, 1..8 = data LSB first, 9 = stop
  always_comb begin
    active_d  = active_q;
    shift_d   = shift_q;
    bit_d     = bit_q;
    clk_cnt_d = clk_cnt_q;
    tx_d      = tx_q;
    if (active_q) begin
      if (bit_end) begin
        clk_cnt_d = '0;
        bit_d     = bit_q + 4'd1;
        if (bit_q == 4'd9) begin
          active_d = 1'b0;
          tx_d     = 1'b1;
        end else if (bit_q == 4'd8) begin
          tx_d = 1'b1;
        end else begin
          tx_d    = shift_q[0];
          shift_d = shift_q >> 1;
        end
      end else begin
        clk_cnt_d = clk_cnt_q + CW'(1);
      end
    end
    if (tx_valid && tx_ready) begin
      active_d  = 1'b1;
      shift_d   = tx_data;
      bit_d     = 4'd0;
      clk_cnt_d = '0;
      tx_d      = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active_q  <= 1'b0;
      shift_q   <= '0;
      bit_q     <= '0;
      clk_cnt_q <= '0;
      tx_q      <= 1'b1;
    end else begin
      active_q  <= active_d;
      shift_q   <= shift_d;
      bit_q     <= bit_d;
      clk_cnt_q <= clk_cnt_d;
      tx_q      <= tx_d;
    end
  end

endmodule

// File: rtl/uart_count_reporter.sv
// Multi-channel rising-edge counter with periodic/requested UART snapshot frames.
// Define COUNT_REPORT_ASCII_EN for a printable ASCII frame instead of the binary one.
module uart_count_reporter
  import uart_count_pkg::*;
#(
  parameter int NUM_CH        = 4,
  parameter int CNT_WIDTH     = 16,
  parameter int CLKS_PER_BIT  = 104,
  parameter int REPORT_PERIOD = 1000000,
  parameter int CLEAR_ON_SNAP = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] ev_in,
  input  logic              report_req,
  output logic              tx,
  output logic              busy,
  output logic              frame_done
);
  localparam int CNT_BYTES = cnt_bytes(CNT_WIDTH);
  localparam int PAD_W     = 8 * CNT_BYTES;
  localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int TMR_W     = $clog2(REPORT_PERIOD);
`ifdef COUNT_REPORT_ASCII_EN
  localparam logic [3:0] DATA_LAST = 4'(2 * CNT_BYTES + 1);
`else
  localparam logic [3:0] DATA_LAST = 4'(CNT_BYTES - 1);
`endif

  logic [NUM_CH-1:0]    sync1_q, sync2_q, sync3_q, edge_det;
  logic [CNT_WIDTH-1:0] cnt_q [NUM_CH];
  logic [CNT_WIDTH-1:0] cnt_d [NUM_CH];
  logic [CNT_WIDTH-1:0] snap_q [NUM_CH];
  logic [CNT_WIDTH-1:0] snap_d [NUM_CH];
  logic [TMR_W-1:0]     timer_q, timer_d;
  logic                 timer_tc, pending_q, pending_d;
  state_t               state_q, state_d;
  logic [CH_W-1:0]      ch_q, ch_d;
  logic [3:0]           idx_q, idx_d;
  logic [7:0]           csum_q, csum_d;
  logic                 last_sent_q, last_sent_d;
  logic                 busy_q, busy_d, done_q, done_d;
  logic                 tx_valid, tx_ready;
  logic [7:0]           tx_data;
  logic [PAD_W-1:0]     padded;

  assign edge_det   = sync2_q & ~sync3_q;
  assign timer_tc   = (timer_q == TMR_W'(REPORT_PERIOD - 1));
  assign busy       = busy_q;
  assign frame_done = done_q;

  // Snapshot takes the pre-increment value; an edge in the SNAP cycle stays live.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      snap_d[i] = snap_q[i];
      cnt_d[i]  = cnt_q[i] + CNT_WIDTH'(edge_det[i]);
      if (state_q == ST_SNAP) begin
        snap_d[i] = cnt_q[i];
        if (CLEAR_ON_SNAP != 0) cnt_d[i] = CNT_WIDTH'(edge_det[i]);
      end
    end
    timer_d   = timer_tc ? '0 : timer_q + TMR_W'(1);
    pending_d = ((state_q == ST_SNAP) ? 1'b0 : pending_q) | timer_tc | report_req;
  end

  always_comb begin
    state_d     = state_q;
    ch_d        = ch_q;
    idx_d       = idx_q;
    csum_d      = csum_q;
    last_sent_d = last_sent_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    tx_valid    = 1'b0;
    tx_data     = 8'h00;
    padded      = '0;
    padded[CNT_WIDTH-1:0] = snap_q[ch_q];
    case (state_q)
      ST_IDLE: if (pending_q) begin
        state_d = ST_SNAP;
        busy_d  = 1'b1;
      end
      ST_SNAP: begin
        ch_d        = '0;
        idx_d       = '0;
        csum_d      = '0;
        last_sent_d = 1'b0;
`ifdef COUNT_REPORT_ASCII_EN
        state_d     = ST_CH_ID;
`else
        state_d     = ST_SYNC;
`endif
      end
      ST_SYNC: begin
        tx_valid = 1'b1;
        tx_data  = SYNC_BYTE;
        if (tx_ready) state_d = ST_CH_ID;
      end
      ST_CH_ID: begin
        tx_valid = 1'b1;
`ifdef COUNT_REPORT_ASCII_EN
        tx_data  = hex_char(4'(ch_q));
`else
        tx_data  = 8'(ch_q);
`endif
        if (tx_ready) begin
          csum_d  = csum_q ^ tx_data;
          idx_d   = '0;
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        tx_valid = 1'b1;
`ifdef COUNT_REPORT_ASCII_EN
        if (idx_q == 4'd0)           tx_data = ASCII_COLON;
        else if (idx_q == DATA_LAST) tx_data = ASCII_SPACE;
        else tx_data = hex_char(4'(padded >> (4 * (2 * CNT_BYTES - int'(idx_q)))));
`else
        tx_data = 8'(padded >> (8 * (CNT_BYTES - 1 - int'(idx_q))));
`endif
        if (tx_ready) begin
          csum_d = csum_q ^ tx_data;
          if (idx_q == DATA_LAST) begin
            idx_d = '0;
            if (ch_q == CH_W'(NUM_CH - 1)) begin
              state_d = ST_CSUM;
            end else begin
              ch_d    = ch_q + CH_W'(1);
              state_d = ST_CH_ID;
            end
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
      end
      ST_CSUM: begin
        // Trailer bytes first, then wait for the serialiser's final stop cycle.
        if (!last_sent_q) begin
          tx_valid = 1'b1;
`ifdef COUNT_REPORT_ASCII_EN
          tx_data  = (idx_q == 4'd0) ? ASCII_CR : ASCII_LF;
          if (tx_ready) begin
            idx_d       = idx_q + 4'd1;
            last_sent_d = (idx_q == 4'd1);
          end
`else
          tx_data  = csum_q;
          if (tx_ready) last_sent_d = 1'b1;
`endif
        end else if (tx_ready) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      sync3_q     <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_q[i]  <= '0;
        snap_q[i] <= '0;
      end
      timer_q     <= '0;
      pending_q   <= 1'b0;
      state_q     <= ST_IDLE;
      ch_q        <= '0;
      idx_q       <= '0;
      csum_q      <= '0;
      last_sent_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      sync1_q     <= ev_in;
      sync2_q     <= sync1_q;
      sync3_q     <= sync2_q;
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_q[i]  <= cnt_d[i];
        snap_q[i] <= snap_d[i];
      end
      timer_q     <= timer_d;
      pending_q   <= pending_d;
      state_q     <= state_d;
      ch_q        <= ch_d;
      idx_q       <= idx_d;
      csum_q      <= csum_d;
      last_sent_q <= last_sent_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tx (
    .clk     (clk),
    .rst     (rst),
    .tx_valid(tx_valid),
    .tx_data (tx_data),
    .tx_ready(tx_ready),
    .tx      (tx)
  );

endmodule

// File: tb/tb_uart_count_reporter.sv
// Bench for uart_count_reporter: directed and random stimulus compared every cycle
// against a behavioural model of counts, triggers, frame contents and tx bit timing.
module tb_uart_count_reporter;
  localparam int NUM_CH        = 2;
  localparam int CNT_WIDTH     = 10;
  localparam int CLKS_PER_BIT  = 4;
  localparam int REPORT_PERIOD = 3000;
  localparam int CLEAR_ON_SNAP = 1;
  localparam int CB            = (CNT_WIDTH + 7) / 8;
`ifdef COUNT_REPORT_ASCII_EN
  localparam int NB = NUM_CH * (3 + 2 * CB) + 2;
`else
  localparam int NB = 2 + NUM_CH * (1 + CB);
`endif
  localparam int BYTE_CLKS = 10 * CLKS_PER_BIT;
  localparam int MASK      = (1 << CNT_WIDTH) - 1;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NUM_CH-1:0] ev_in = '0;
  logic              report_req = 1'b0;
  logic              tx, busy, frame_done;

  always #5 clk = ~clk;

  uart_count_reporter #(
    .NUM_CH       (NUM_CH),
    .CNT_WIDTH    (CNT_WIDTH),
    .CLKS_PER_BIT (CLKS_PER_BIT),
    .REPORT_PERIOD(REPORT_PERIOD),
    .CLEAR_ON_SNAP(CLEAR_ON_SNAP)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .ev_in     (ev_in),
    .report_req(report_req),
    .tx        (tx),
    .busy      (busy),
    .frame_done(frame_done)
  );

  int n_chk = 0;
  int n_pass = 0;
  int k, k0, done_edge, mdl_frames, dut_frames;
  int cnt [NUM_CH];
  int snap [NUM_CH];
  logic [NUM_CH-1:0] a1, a2, a3;
  bit pending, idle;
  logic [7:0] frm [$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, k);
    else n_pass++;
  endtask

  function automatic logic [7:0] hexc(input int n);
    return (n < 10) ? 8'(48 + n) : 8'(55 + n);
  endfunction

  task automatic model_reset();
    k = 0; k0 = -100; done_edge = -1;
    a1 = '0; a2 = '0; a3 = '0;
    pending = 1'b0; idle = 1'b1;
    for (int c = 0; c < NUM_CH; c++) begin cnt[c] = 0; snap[c] = 0; end
  endtask

  task automatic build_frame();
    logic [7:0] cs, b;
    string s;
    frm.delete();
    cs = 8'h00;
`ifdef COUNT_REPORT_ASCII_EN
    for (int c = 0; c < NUM_CH; c++) begin
      frm.push_back(hexc(c));
      frm.push_back(8'h3A);
      for (int d = 2 * CB - 1; d >= 0; d--) frm.push_back(hexc((snap[c] >> (4 * d)) & 15));
      frm.push_back(8'h20);
    end
    frm.push_back(8'h0D);
    frm.push_back(8'h0A);
`else
    frm.push_back(8'hA5);
    for (int c = 0; c < NUM_CH; c++) begin
      b = 8'(c); frm.push_back(b); cs ^= b;
      for (int d = CB - 1; d >= 0; d--) begin
        b = 8'((snap[c] >> (8 * d)) & 255); frm.push_back(b); cs ^= b;
      end
    end
    frm.push_back(cs);
`endif
    s = "";
    foreach (frm[i]) s = {s, $sformatf(" %02h", frm[i])};
    $display("frame %0d snap at edge %0d: ch0=%0d ch%0d=%0d bytes%s",
             mdl_frames, k, snap[0], NUM_CH - 1, snap[NUM_CH-1], s);
  endtask

  // One clock edge of the reference behaviour: 3-clk input latency, wrapping
  // counters, trigger/pending rules, and the fixed frame schedule.
  task automatic model_edge(input logic [NUM_CH-1:0] ev, input bit req);
    logic [NUM_CH-1:0] inc;
    bit trig, p_old;
    k++;
    inc   = a2 & ~a3;
    trig  = req || (k % REPORT_PERIOD == 0);
    p_old = pending;
    if (!idle && k == k0 + 1) begin
      for (int c = 0; c < NUM_CH; c++) begin
        snap[c] = cnt[c];
        cnt[c]  = (CLEAR_ON_SNAP != 0) ? int'(inc[c]) : ((cnt[c] + int'(inc[c])) & MASK);
      end
      pending = trig;
      build_frame();
    end else begin
      for (int c = 0; c < NUM_CH; c++) cnt[c] = (cnt[c] + int'(inc[c])) & MASK;
      pending = pending | trig;
    end
    a3 = a2; a2 = a1; a1 = ev;
    if (idle && p_old) begin
      idle = 1'b0; k0 = k; done_edge = k + 2 + NB * BYTE_CLKS;
    end else if (!idle && k == done_edge) begin
      idle = 1'b1; mdl_frames++;
    end
  endtask

  function automatic logic exp_tx();
    int t, b, p;
    if (idle || k < k0 + 2) return 1'b1;
    t = k - (k0 + 2);
    if (t >= NB * BYTE_CLKS) return 1'b1;
    b = t / BYTE_CLKS;
    p = (t % BYTE_CLKS) / CLKS_PER_BIT;
    if (p == 0) return 1'b0;
    if (p == 9) return 1'b1;
    return frm[b][p-1];
  endfunction

  task automatic step(input logic [NUM_CH-1:0] ev, input bit req);
    ev_in = ev; report_req = req;
    @(posedge clk);
    model_edge(ev, req);
    #1;
    if (frame_done === 1'b1) dut_frames++;
    chk("tx", tx, exp_tx());
    chk("busy", busy, !idle);
    chk("frame_done", frame_done, k == done_edge);
    @(negedge clk);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) step('0, 1'b0);
  endtask

  task automatic pulse(input int c, input int n);
    for (int i = 0; i < n; i++) begin
      step(NUM_CH'(1) << c, 1'b0);
      step('0, 1'b0);
    end
  endtask

  task automatic run_frames();
    int n = 0;
    while ((!idle || pending) && n < 20 * NB * BYTE_CLKS) begin step('0, 1'b0); n++; end
    chk("frames_settled", busy, 1'b0);
  endtask

  task automatic do_reset(input int cycles);
    ev_in = '0; report_req = 1'b0; rst = 1'b1;
    #1;
    chk("rst_tx", tx, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_frame_done", frame_done, 1'b0);
    repeat (cycles) @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    logic [NUM_CH-1:0] ev_r;
    model_reset();
    mdl_frames = 0; dut_frames = 0;
    @(negedge clk);
    do_reset(5);
    idle_cycles(10);

    // 3 edges ch0, 5 edges ch1, manual request
    pulse(0, 3); pulse(1, 5); idle_cycles(4);
    step('0, 1'b1); run_frames(); idle_cycles(5);

    // Several requests during one frame give exactly one follow-up frame
    step('0, 1'b1); idle_cycles(60); step('0, 1'b1); idle_cycles(100); step('0, 1'b1);
    run_frames(); idle_cycles(10);

    // Edge landing in the SNAP cycle: excluded now, reported next frame
    step(NUM_CH'(1), 1'b1); step(NUM_CH'(1), 1'b0); step(NUM_CH'(1), 1'b0);
    run_frames(); idle_cycles(5);
    step('0, 1'b1); run_frames(); idle_cycles(5);

    // Counter wrap: 2^CNT_WIDTH + 1 edges report as 1
    do_reset(5);
    pulse(0, (1 << CNT_WIDTH) + 1); idle_cycles(4);
    step('0, 1'b1); run_frames(); idle_cycles(5);

    // Reset during the start bit of the sync byte, then silence until a trigger
    step('0, 1'b1); idle_cycles(3);
    do_reset(5);
    idle_cycles(500);

    // Random events and requests, including timer-driven reports
    ev_r = '0;
    for (int i = 0; i < 12000; i++) begin
      for (int c = 0; c < NUM_CH; c++) if ($urandom_range(5) == 0) ev_r[c] = ~ev_r[c];
      step(ev_r, $urandom_range(299) == 0);
    end
    step('0, 1'b0);
    run_frames(); idle_cycles(5);

    chk("frame_count", dut_frames, mdl_frames);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
